// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared defaults for the RAM-backed first-word-fall-through FIFO.
package ram_fifo_ctrl_pkg;

  localparam int unsigned RFC_DATA_WIDTH   = 512;
  localparam int unsigned RFC_ADDR_WIDTH   = 5;
  localparam int unsigned RFC_AFULL_MARGIN = 4;

  // Default almost-full threshold: a few slots short of the RAM depth.
  function automatic int unsigned afull_default(input int unsigned aw);
    return (32'd1 << aw) - RFC_AFULL_MARGIN;
  endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Valid/ready beat stream used on both sides of the FIFO.
interface ram_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = ram_fifo_ctrl_pkg::RFC_DATA_WIDTH
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ram_simple_dual.sv
// Simple dual-port RAM: write port A, registered read port B (dob holds when enb=0).
module ram_simple_dual #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DISTR      = 0
) (
  input  logic                  clk,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dia,
  input  logic                  enb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] dob
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ena && wea) mem[addra] <= dia;
  end

  // Distributed RAM reads asynchronously into an output register; block RAM reads synchronously.
  generate
    if (DISTR != 0) begin : g_distr
      logic [DATA_WIDTH-1:0] rd_c;
      assign rd_c = mem[addrb];
      always_ff @(posedge clk) begin
        if (enb) dob <= rd_c;
      end
    end else begin : g_block
      always_ff @(posedge clk) begin
        if (enb) dob <= mem[addrb];
      end
    end
  endgenerate

endmodule

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO: sequences the RAM write port from the producer
// and prefetches the read port into the RAM output register for the consumer.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RFC_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RFC_ADDR_WIDTH,
  parameter int unsigned DISTR      = 0,
  parameter int unsigned AFULL_LVL  = afull_default(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  ram_fifo_ctrl_if.slave        s,
  ram_fifo_ctrl_if.master       m,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  almost_full,
  output logic                  empty
);

  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned CW    = ADDR_WIDTH + 2;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          m_valid_q, m_valid_d;
  logic          afull_q, afull_d;
  logic [PW-1:0] ram_used_c, used_nxt_c;
  logic          s_ready_c, push_c, pop_c, load_c;

  // Handshakes and next-state: flush wins, a load refills the output register.
  always_comb begin
    ram_used_c = wr_ptr_q - rd_ptr_q;
    s_ready_c  = (ram_used_c != PW'(DEPTH)) && !flush;
    push_c     = s.valid && s_ready_c;
    pop_c      = m_valid_q && m.ready;
    load_c     = (ram_used_c != '0) && (!m_valid_q || pop_c) && !flush;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    m_valid_d = m_valid_q;

    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      m_valid_d = 1'b0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (load_c) begin
        rd_ptr_d  = rd_ptr_q + PW'(1);
        m_valid_d = 1'b1;
      end else if (pop_c) begin
        m_valid_d = 1'b0;
      end
    end

    used_nxt_c = wr_ptr_d - rd_ptr_d;
    afull_d    = 32'(used_nxt_c) >= AFULL_LVL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      m_valid_q <= 1'b0;
      afull_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      m_valid_q <= m_valid_d;
      afull_q   <= afull_d;
    end
  end

  ram_simple_dual #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DISTR      (DISTR)
  ) u_ram (
    .clk   (clk),
    .ena   (push_c),
    .wea   (push_c),
    .addra (wr_ptr_q[ADDR_WIDTH-1:0]),
    .dia   (s.data),
    .enb   (load_c),
    .addrb (rd_ptr_q[ADDR_WIDTH-1:0]),
    .dob   (m.data)
  );

  assign s.ready     = s_ready_c;
  assign m.valid     = m_valid_q;
  assign almost_full = afull_q;
  assign count       = CW'(ram_used_c) + CW'(m_valid_q);
  assign empty       = (count == '0);

endmodule
